// File: rtl/tick_scheduler_if.sv
// Configuration write port of tick_scheduler: a valid/ready handshake that carries
// a channel index and a new period in base strobes.
interface tick_scheduler_if #(
    parameter int CHAN_W   = 2,
    parameter int PERIOD_W = 16
);
    logic                cfg_valid_in;
    logic                cfg_ready_out;
    logic [CHAN_W-1:0]   cfg_chan_in;
    logic [PERIOD_W-1:0] cfg_period_in;

    modport master (
        output cfg_valid_in,
        output cfg_chan_in,
        output cfg_period_in,
        input  cfg_ready_out
    );

    modport slave (
        input  cfg_valid_in,
        input  cfg_chan_in,
        input  cfg_period_in,
        output cfg_ready_out
    );
endinterface

// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler produces a base strobe, and each channel divides it by a
// runtime-programmable period into a one-cycle enable pulse and a square-wave level.
module tick_scheduler #(
    parameter int CLOCK_MHZ = 12,
    parameter int BASE_HZ   = 1000,
    parameter int CHANNELS  = 4,
    parameter int PERIOD_W  = 16
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    tick_scheduler_if.slave     cfg,
    output logic                base_tick_out,
    output logic [CHANNELS-1:0] tick_out,
    output logic [CHANNELS-1:0] level_out
);
    localparam int          CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [31:0] PRESCALE = 32'((CLOCK_MHZ * 1000000) / BASE_HZ);

    typedef enum logic {
        S_IDLE,
        S_COMMIT
    } cfg_state_t;

    cfg_state_t          r_state;
    logic                r_ready;
    logic [CHAN_W-1:0]   r_hold_chan;
    logic [PERIOD_W-1:0] r_hold_period;
    logic [31:0]         r_presc;
    logic                r_base_tick;
    logic [PERIOD_W-1:0] r_period [CHANNELS];
    logic [PERIOD_W-1:0] r_count  [CHANNELS];
    logic [CHANNELS-1:0] r_tick;
    logic [CHANNELS-1:0] r_level;
    logic                w_accept;

    assign w_accept          = cfg.cfg_valid_in && r_ready;
    assign cfg.cfg_ready_out = r_ready;
    assign base_tick_out     = r_base_tick;
    assign tick_out          = r_tick;
    assign level_out         = r_level;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_presc     <= '0;
            r_base_tick <= 1'b0;
        end else if (r_presc == PRESCALE - 32'd1) begin
            r_presc     <= '0;
            r_base_tick <= 1'b1;
        end else begin
            r_presc     <= r_presc + 32'd1;
            r_base_tick <= 1'b0;
        end
    end

    // A write is held for one cycle and applied in COMMIT, so at most one write lands every two cycles.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_hold_chan   <= '0;
            r_hold_period <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hold_chan   <= cfg.cfg_chan_in;
                        r_hold_period <= cfg.cfg_period_in;
                        r_state       <= S_COMMIT;
                        r_ready       <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the period/count arrays are reset on purpose: period 0 is what defines a disabled channel.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_period[i] <= '0;
                r_count[i]  <= '0;
            end
            r_tick  <= '0;
            r_level <= '0;
        end else begin
            r_tick <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                // A commit to this channel swallows a coinciding strobe; out-of-range indices match nothing.
                if (r_state == S_COMMIT && int'(r_hold_chan) == i) begin
                    r_period[i] <= r_hold_period;
                    r_count[i]  <= '0;
                end else if (r_base_tick && r_period[i] != '0) begin
                    if (r_count[i] == r_period[i] - PERIOD_W'(1)) begin
                        r_count[i] <= '0;
                        r_tick[i]  <= 1'b1;
                        r_level[i] <= ~r_level[i];
                    end else begin
                        r_count[i] <= r_count[i] + PERIOD_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with PRESCALE=4: expected tick cycles and levels are queued per channel
// when a write is made and consumed by a per-cycle monitor as the design produces pulses.
module tb_tick_scheduler;
    localparam int NCH     = 4;
    localparam int PRE     = 4;
    localparam int HORIZON = 4000;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    logic           clk_in   = 1'b0;
    logic           rst_n_in = 1'b1;
    logic           base_tick_out;
    logic [NCH-1:0] tick_out;
    logic [NCH-1:0] level_out;
    logic           base3;
    logic [2:0]     tick3;
    logic [2:0]     level3;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  exp_q [NCH][$];
    logic cur_lvl [NCH];

    tick_scheduler_if #(.CHAN_W(2), .PERIOD_W(8)) cfg_if ();
    tick_scheduler_if #(.CHAN_W(2), .PERIOD_W(8)) cfg3_if ();

    tick_scheduler #(
        .CLOCK_MHZ(1), .BASE_HZ(250000), .CHANNELS(4), .PERIOD_W(8)
    ) u_dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .cfg           (cfg_if),
        .base_tick_out (base_tick_out),
        .tick_out      (tick_out),
        .level_out     (level_out)
    );

    tick_scheduler #(
        .CLOCK_MHZ(1), .BASE_HZ(250000), .CHANNELS(3), .PERIOD_W(8)
    ) u_dut3 (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .cfg           (cfg3_if),
        .base_tick_out (base3),
        .tick_out      (tick3),
        .level_out     (level3)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Queue the ticks a channel must produce after a commit at cycle w with period p.
    task automatic schedule(input int c, input int p, input int w);
        logic l;
        int   k;
        l = cur_lvl[c];
        k = 0;
        exp_q[c].delete();
        if (p != 0) begin
            for (int s = (w / PRE + 1) * PRE; s <= HORIZON; s += PRE) begin
                k++;
                if (k % p == 0) begin
                    l = ~l;
                    exp_q[c].push_back('{cyc: s + 1, lvl: l});
                end
            end
        end
    endtask

    // Advance one cycle and compare base strobe, ticks and levels of the 4-channel design.
    task automatic step();
        logic exp_base;
        ev_t  e;
        @(negedge clk_in);
        exp_base = (cyc > 0) && (cyc % PRE == 0);
        n_checks++;
        if (base_tick_out !== exp_base) begin
            n_errors++;
            $display("FAIL base_tick cyc=%0d got=%b exp=%b", cyc, base_tick_out, exp_base);
        end
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if (exp_q[c].size() > 0 && exp_q[c][0].cyc == cyc) begin
                e = exp_q[c].pop_front();
                cur_lvl[c] = e.lvl;
                if (tick_out[c] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL tick ch=%0d cyc=%0d got=%b exp=1", c, cyc, tick_out[c]);
                end
            end else if (tick_out[c] !== 1'b0) begin
                n_errors++;
                $display("FAIL tick ch=%0d cyc=%0d got=%b exp=0", c, cyc, tick_out[c]);
            end
            n_checks++;
            if (level_out[c] !== cur_lvl[c]) begin
                n_errors++;
                $display("FAIL level ch=%0d cyc=%0d got=%b exp=%b", c, cyc, level_out[c], cur_lvl[c]);
            end
        end
    endtask

    task automatic cfg_write(input int c, input int p, output int w);
        cfg_if.cfg_valid_in  = 1'b1;
        cfg_if.cfg_chan_in   = 2'(c);
        cfg_if.cfg_period_in = 8'(p);
        n_checks++;
        if (cfg_if.cfg_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_ready_idle cyc=%0d got=%b exp=1", cyc, cfg_if.cfg_ready_out);
        end
        step();
        w = cyc;
        cfg_if.cfg_valid_in = 1'b0;
        n_checks++;
        if (cfg_if.cfg_ready_out !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_ready_commit cyc=%0d got=%b exp=0", cyc, cfg_if.cfg_ready_out);
        end
        schedule(c, p, w);
        step();
    endtask

    task automatic test_reset();
        #1 rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if ({base_tick_out, tick_out, level_out} !== 9'b0 || cfg_if.cfg_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state got=%b_%b_%b rdy=%b exp=0_0000_0000 rdy=1",
                     base_tick_out, tick_out, level_out, cfg_if.cfg_ready_out);
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if (cfg_if.cfg_ready_out !== 1'b1) begin
                n_errors++;
                $display("FAIL idle_ready cyc=%0d got=%b exp=1", cyc, cfg_if.cfg_ready_out);
            end
        end
    endtask

    task automatic test_periods();
        int w;
        cfg_write(0, 1, w);
        cfg_write(2, 3, w);
        repeat (60) step();
    endtask

    task automatic test_back_to_back();
        int w;
        cfg_if.cfg_valid_in  = 1'b1;
        cfg_if.cfg_chan_in   = 2'd3;
        cfg_if.cfg_period_in = 8'd2;
        n_checks++;
        if (cfg_if.cfg_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ready_first got=%b exp=1", cfg_if.cfg_ready_out);
        end
        step();
        w = cyc;
        schedule(3, 2, w);
        cfg_if.cfg_chan_in   = 2'd2;
        cfg_if.cfg_period_in = 8'd1;
        n_checks++;
        if (cfg_if.cfg_ready_out !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_ready_second got=%b exp=0", cfg_if.cfg_ready_out);
        end
        step();
        n_checks++;
        if (cfg_if.cfg_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ready_third got=%b exp=1", cfg_if.cfg_ready_out);
        end
        cfg_if.cfg_chan_in   = 2'd1;
        cfg_if.cfg_period_in = 8'd4;
        step();
        w = cyc;
        cfg_if.cfg_valid_in = 1'b0;
        schedule(1, 4, w);
        repeat (40) step();
    endtask

    task automatic test_commit_collision();
        int w;
        int guard;
        guard = 0;
        while (cyc % PRE != PRE - 1 && guard < 8) begin
            step();
            guard++;
        end
        cfg_write(1, 2, w);
        repeat (30) step();
    endtask

    task automatic test_period_zero();
        int w;
        int guard;
        guard = 0;
        while (!(tick_out[2] === 1'b1 && cur_lvl[2] === 1'b1) && guard < 200) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_errors++;
            $display("FAIL level2_high_wait got=timeout exp=tick_with_level_1");
        end
        cfg_write(2, 0, w);
        repeat (40) step();
        n_checks++;
        if (level_out[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL level2_frozen got=%b exp=1", level_out[2]);
        end
    endtask

    task automatic test_bad_channel();
        int         w0;
        logic [2:0] e3;
        logic       eb;
        cfg3_if.cfg_valid_in  = 1'b1;
        cfg3_if.cfg_chan_in   = 2'd0;
        cfg3_if.cfg_period_in = 8'd1;
        step();
        w0 = cyc;
        cfg3_if.cfg_valid_in = 1'b0;
        step();
        n_checks++;
        if (cfg3_if.cfg_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL bad_chan_ready_idle got=%b exp=1", cfg3_if.cfg_ready_out);
        end
        cfg3_if.cfg_valid_in  = 1'b1;
        cfg3_if.cfg_chan_in   = 2'(7);
        cfg3_if.cfg_period_in = 8'd2;
        step();
        n_checks++;
        if (cfg3_if.cfg_ready_out !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_chan_ready_commit got=%b exp=0", cfg3_if.cfg_ready_out);
        end
        cfg3_if.cfg_valid_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            e3    = '0;
            e3[0] = ((cyc - 1) % PRE == 0) && (cyc - 1 > w0);
            eb    = (cyc % PRE == 0);
            n_checks++;
            if (tick3 !== e3 || base3 !== eb) begin
                n_errors++;
                $display("FAIL bad_chan_ticks cyc=%0d got=%b/%b exp=%b/%b", cyc, tick3, base3, e3, eb);
            end
        end
    endtask

    task automatic test_async_reset();
        cfg_if.cfg_valid_in  = 1'b1;
        cfg_if.cfg_chan_in   = 2'd0;
        cfg_if.cfg_period_in = 8'd2;
        @(posedge clk_in);
        #2;
        n_checks++;
        if (cfg_if.cfg_ready_out !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_reset_commit got=%b exp=0", cfg_if.cfg_ready_out);
        end
        rst_n_in            = 1'b0;
        cfg_if.cfg_valid_in = 1'b0;
        #1;
        n_checks++;
        if ({base_tick_out, tick_out, level_out} !== 9'b0 || cfg_if.cfg_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset got=%b_%b_%b rdy=%b exp=0_0000_0000 rdy=1",
                     base_tick_out, tick_out, level_out, cfg_if.cfg_ready_out);
        end
        repeat (2) @(negedge clk_in);
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            cur_lvl[c] = 1'b0;
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if (cfg_if.cfg_ready_out !== 1'b1) begin
                n_errors++;
                $display("FAIL post_reset_ready cyc=%0d got=%b exp=1", cyc, cfg_if.cfg_ready_out);
            end
        end
    endtask

    initial begin
        cfg_if.cfg_valid_in   = 1'b0;
        cfg_if.cfg_chan_in    = '0;
        cfg_if.cfg_period_in  = '0;
        cfg3_if.cfg_valid_in  = 1'b0;
        cfg3_if.cfg_chan_in   = '0;
        cfg3_if.cfg_period_in = '0;
        for (int c = 0; c < NCH; c++) cur_lvl[c] = 1'b0;

        test_reset();
        test_periods();
        test_back_to_back();
        test_commit_collision();
        test_period_zero();
        test_bad_channel();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shared timebase scheduler for the VGA/LED subsystems.
- Replaces per-consumer free-running dividers with one common prescaler that generates a base strobe.
- Serves CHANNELS independent consumers. Each consumer has a runtime-programmable period, counted in base strobes.
- Emits single-cycle clock-enable pulses and divided square-wave levels. All outputs stay in the clk_in domain; no derived clocks.

Parameters:
- CLOCK_MHZ, 12: input clock frequency in MHz.
- BASE_HZ, 1000: base strobe rate in Hz. PRESCALE = (CLOCK_MHZ*1000000)/BASE_HZ, computed as a 32-bit localparam. PRESCALE must be >= 2.
- CHANNELS, 4: number of scheduled consumers, 1..16.
- PERIOD_W, 16: width of each channel's period register and counter.
- CHAN_W, derived: max(1, $clog2(CHANNELS)), width of the channel select.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_n_in  input  1  reset; asynchronous assert, active-low. Deassertion is externally synchronised.
- cfg_valid_in  input  1  a configuration write is offered.
- cfg_ready_out  output  1  scheduler can accept a write this cycle.
- cfg_chan_in  input  CHAN_W  channel index of the write.
- cfg_period_in  input  PERIOD_W  new period in base strobes; 0 disables the channel.
- base_tick_out  output  1  one-cycle base strobe at BASE_HZ.
- tick_out  output  CHANNELS  per-channel one-cycle enable pulse.
- level_out  output  CHANNELS  per-channel square wave; toggles on each tick.

Behaviour:
- Reset (rst_n_in low, asynchronous) forces the following:
  - prescaler = 0; base_tick_out = 0.
  - All period regs = 0, so every channel is disabled.
  - All channel counters = 0; tick_out = 0; level_out = 0.
  - cfg FSM = IDLE, so cfg_ready_out = 1.
  - Any held configuration write is discarded.
- Prescaler:
  - 32-bit counter p.
  - If p == PRESCALE-1: p <= 0 and base_tick_out <= 1.
  - Otherwise: p <= p+1 and base_tick_out <= 0.
  - Result: the first base_tick_out is high in the PRESCALE-th cycle after reset release, then every PRESCALE cycles.
- Channel i, evaluated only in cycles where base_tick_out == 1:
  - If period_i == 0: count_i held at 0, no tick, level_i held.
  - Else if count_i == period_i-1: count_i <= 0, tick_out[i] <= 1, level_i <= ~level_i.
  - Else: count_i <= count_i+1.
  - tick_out[i] is 0 in every other cycle.
  - Latency: tick_out[i] is high exactly one cycle after the qualifying base_tick_out cycle.
  - Period P gives one tick every P base strobes, i.e. every P*PRESCALE clocks.
  - level_out[i] period is 2*P base strobes.
- Config FSM, two states:
  - IDLE: cfg_ready_out = 1. On cfg_valid_in & cfg_ready_out, capture chan/period into hold regs and go to COMMIT.
  - COMMIT: cfg_ready_out = 0. period[hold_chan] <= hold_period, count[hold_chan] <= 0; level is unchanged. Return to IDLE.
  - Throughput: at most one write per 2 cycles. The value on cfg_* while in COMMIT is ignored.
- Commit boundary cases:
  - Commit in the same cycle as base_tick_out, same channel: commit wins. No count increment and no tick from that strobe. Other channels advance normally.
  - First tick after a commit of P != 0 follows the P-th base strobe after the commit cycle.
  - Commit of period 0: the channel stops immediately. level_out freezes at its current value. Any tick_out already registered still completes its single cycle.
  - Re-writing the same period restarts the channel's phase (counter cleared).
  - cfg_chan_in >= CHANNELS: handshake completes normally, no state changes.
- Arithmetic: count_i is PERIOD_W bits, compared against period_i-1 using PERIOD_W-bit arithmetic. The period_i==0 guard prevents wrap. Maximum period is 2^PERIOD_W - 1.

Test Plan:
- Bench parameters for all scenarios: CLOCK_MHZ=1, BASE_HZ=250000 (PRESCALE=4), CHANNELS=4, PERIOD_W=8.
- Reset release, no writes -> base_tick_out high at cycles 4, 8, 12…; tick_out=0 and level_out=0 for 100 cycles; cfg_ready_out=1.
- Write ch0 period 1 and ch2 period 3 -> tick_out[0] at every base strobe +1 cycle. tick_out[2] every 12 cycles, first after the 3rd strobe following commit. level_out[2] period 24 cycles.
- Back-to-back valid for 3 cycles -> cfg_ready_out pattern 1,0,1; exactly 2 writes accepted; the middle-cycle data is ignored.
- Commit to ch1 period 2 landing in a base_tick_out cycle -> ch1 does not count that strobe. First tick_out[1] after the 2 following strobes. ch0 ticks unaffected.
- Write ch2 period 0 mid-run with level_out[2]=1 -> no further tick_out[2]; level_out[2] stays 1. Write cfg_chan=7 (CHAN_W=2 aliasing excluded; use CHANNELS=3 variant) -> no state change.
- Assert rst_n_in asynchronously between edges during COMMIT -> all outputs 0 immediately, cfg_ready_out=1 immediately. After release: no ticks, and the pending write is lost.
